// File: rtl/rgb_pwm_sequencer.sv
// Multi-channel PWM LED sequencer with static, rotate and breathe modes.
// Breathe mode (level register and multiplier) is built only when RGB_PWM_BREATHE_EN is defined.
module rgb_pwm_sequencer #(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16,
  localparam int CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic [CHANNELS*PWM_BITS-1:0] duty_in,
  input  logic [PRESCALE_BITS-1:0]     step_div,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic [CH_BITS-1:0]           active_ch,
  output logic [PWM_BITS-1:0]          level
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_ROTATE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  logic [PWM_BITS-1:0]                cnt_q;
  logic [PRESCALE_BITS-1:0]           presc_q;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  eff_q;
  logic [CHANNELS-1:0][PWM_BITS-1:0]  eff_d;
  logic [CHANNELS-1:0]                cmp;
  logic [CHANNELS-1:0]                pwm_q;

  mode_t               mode_q, mode_d;
  logic [CH_BITS-1:0]  active_q, active_d;

  logic boundary;
  logic tick;
  logic mode_changed;

  assign boundary     = enable && (cnt_q == '1);
  assign tick         = enable && (presc_q >= step_div);
  assign mode_changed = boundary && (mode != mode_q);

`ifdef RGB_PWM_BREATHE_EN
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  dir_t                dir_q, dir_d;
  logic [PWM_BITS-1:0] level_q, level_d;

  function automatic logic [PWM_BITS-1:0] breathe_scale(input logic [PWM_BITS-1:0] duty,
                                                        input logic [PWM_BITS-1:0] lvl);
    logic [2*PWM_BITS-1:0] prod;
    prod = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, lvl};
    return prod[2*PWM_BITS-1:PWM_BITS];
  endfunction

  assign level = level_q;
`else
  assign level = '0;
`endif

  // Sequencing state register: latched mode, rotate pointer, breathe level/direction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q   <= MODE_OFF;
      active_q <= '0;
`ifdef RGB_PWM_BREATHE_EN
      level_q  <= '0;
      dir_q    <= DIR_UP;
`endif
    end else begin
      mode_q   <= mode_d;
      active_q <= active_d;
`ifdef RGB_PWM_BREATHE_EN
      level_q  <= level_d;
      dir_q    <= dir_d;
`endif
    end
  end

  // A mode change at a boundary restarts the sequence and overrides any same-cycle tick
  always_comb begin
    mode_d   = mode_q;
    active_d = active_q;
`ifdef RGB_PWM_BREATHE_EN
    level_d  = level_q;
    dir_d    = dir_q;
`endif
    if (boundary) begin
      mode_d = mode_t'(mode);
    end
    if (mode_changed) begin
      active_d = '0;
`ifdef RGB_PWM_BREATHE_EN
      level_d  = '0;
      dir_d    = DIR_UP;
`endif
    end else if (tick) begin
      case (mode_q)
        MODE_ROTATE: begin
          if (active_q == CH_BITS'(CHANNELS - 1)) begin
            active_d = '0;
          end else begin
            active_d = active_q + 1'b1;
          end
        end
`ifdef RGB_PWM_BREATHE_EN
        // The turning tick already steps in the new direction, so peaks are held one tick
        MODE_BREATHE: begin
          if (dir_q == DIR_UP) begin
            if (level_q == '1) begin
              dir_d   = DIR_DOWN;
              level_d = level_q - 1'b1;
            end else begin
              level_d = level_q + 1'b1;
            end
          end else begin
            if (level_q == '0) begin
              dir_d   = DIR_UP;
              level_d = level_q + 1'b1;
            end else begin
              level_d = level_q - 1'b1;
            end
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Effective duties use the incoming mode but the pre-tick rotate pointer and level
  always_comb begin
    eff_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode_t'(mode))
        MODE_OFF:    eff_d[c] = '0;
        MODE_STATIC: eff_d[c] = duty_in[c*PWM_BITS +: PWM_BITS];
        MODE_ROTATE: eff_d[c] = (active_q == CH_BITS'(c)) ? duty_in[c*PWM_BITS +: PWM_BITS] : '0;
`ifdef RGB_PWM_BREATHE_EN
        MODE_BREATHE: eff_d[c] = breathe_scale(duty_in[c*PWM_BITS +: PWM_BITS], level_q);
`else
        MODE_BREATHE: eff_d[c] = duty_in[c*PWM_BITS +: PWM_BITS];
`endif
        default:     eff_d[c] = '0;
      endcase
    end
  end

  always_comb begin
    cmp = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cmp[c] = (cnt_q < eff_q[c]);
    end
  end

  // PWM counter, step prescaler, boundary duty latch and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      presc_q <= '0;
      eff_q   <= '0;
      pwm_q   <= '0;
    end else begin
      pwm_q <= enable ? cmp : '0;
      if (enable) begin
        cnt_q   <= cnt_q + 1'b1;
        presc_q <= tick ? '0 : presc_q + 1'b1;
      end
      if (boundary) begin
        eff_q <= eff_d;
      end
    end
  end

  assign pwm_out   = pwm_q;
  assign active_ch = active_q;

endmodule
